// File: rtl/fpu_pkg.sv
// Shared types and constants for the fpu_seq floating-point unit.
// Holds the operation/state encodings, IEEE-754 single field layouts,
// canonical special values and small helpers used by the datapath.
package fpu_pkg;

  localparam int          EXP_BIAS     = 127;
  localparam int          EXP_MAX      = 255;
  localparam int          MANT_W       = 23;
  localparam logic [31:0] QNAN_DEFAULT = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF      = 32'h7F80_0000;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_EXEC,
    ST_NORM,
    ST_PACK,
    ST_DONE
  } state_t;

  // Raw IEEE-754 single layout
  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  // Unpacked operand: hidden bit restored, denormals already flushed to zero
  typedef struct packed {
    logic            sign;
    logic [7:0]      exp;
    logic [MANT_W:0] mant;
  } unp_t;

  function automatic logic [31:0] f_inf(input logic s);
    f_inf = {s, POS_INF[30:0]};
  endfunction

  function automatic logic [31:0] f_zero(input logic s);
    f_zero = {s, 31'd0};
  endfunction

  // Index of the most significant set bit (0 when v is zero)
  function automatic logic [5:0] lead_one(input logic [47:0] v);
    lead_one = '0;
    for (int i = 0; i < 48; i++)
      if (v[i]) lead_one = 6'(i);
  endfunction

endpackage

// File: rtl/fpu_div_iter.sv
// Restoring mantissa divider, one quotient bit per clock.
// Ports:
//   clk, reset_n       clock, synchronous active-low reset (aborts a division)
//   start              load dividend/divisor and begin iterating
//   dividend, divisor  24-bit mantissas with hidden bit (divisor >= 2^23)
//   quotient           DIV_BITS-bit quotient, MSB = integer bit
//   done               high during the cycle whose edge writes the final
//                      quotient bit; quotient is complete from the next cycle
module fpu_div_iter #(
  parameter int DIV_BITS = 25
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [23:0]         dividend,
  input  logic [23:0]         divisor,
  output logic [DIV_BITS-1:0] quotient,
  output logic                done
);

  localparam int CNT_W = $clog2(DIV_BITS + 1);

  // Remainder stays below 2*divisor, so 26 bits covers it after the shift
  logic [25:0]         r_rem;
  logic [23:0]         r_dvs;
  logic [DIV_BITS-1:0] r_q;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_run;

  logic [25:0] w_trial;
  logic        w_ge;

  assign w_ge     = (r_rem >= {2'b00, r_dvs});
  assign w_trial  = r_rem - {2'b00, r_dvs};
  assign done     = r_run && (r_cnt == CNT_W'(DIV_BITS - 1));
  assign quotient = r_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rem <= '0;
      r_dvs <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_rem <= {2'b00, dividend};
      r_dvs <= divisor;
      r_q   <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_q   <= {r_q[DIV_BITS-2:0], w_ge};
      r_rem <= (w_ge ? w_trial : r_rem) << 1;
      r_cnt <= r_cnt + 1'b1;
      if (done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/fpu_seq.sv
// Multi-cycle single-precision FPU (ADD/SUB/MUL/DIV), round toward zero.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   start         request strobe, only honoured while idle
//   fpuOp         0=ADD 1=SUB 2=MUL 3=DIV
//   opA, opB      IEEE-754 single operands
//   busy          high from the cycle after accept through the done cycle
//   done          one-cycle strobe, fpuOut valid from this cycle
//   fpuOut        result, held until the next operation completes
// Schedule: IDLE -> UNPACK -> EXEC (1 cycle, or DIV_BITS for DIV) -> NORM
//           -> PACK -> DONE. Specials are resolved in UNPACK but ride the
//           same schedule so latency depends only on the op class.
module fpu_seq
  import fpu_pkg::*;
#(
  parameter int          DIV_BITS = 25,
  parameter logic [31:0] QNAN     = QNAN_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  fpuOp,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic        busy,
  output logic        done,
  output logic [31:0] fpuOut
);

  localparam logic signed [10:0] L_BIAS    = 11'(EXP_BIAS);
  localparam logic signed [10:0] L_EXP_MAX = 11'(EXP_MAX);

  state_t r_state, w_next;

  logic [31:0] r_opa, r_opb;
  op_t         r_op;

  // unpack / specials
  fp32_t       w_fa, w_fb;
  unp_t        w_ua, w_ub, r_ua, r_ub;
  logic        w_a_zero, w_a_inf, w_a_nan;
  logic        w_b_zero, w_b_inf, w_b_nan;
  logic        w_sx;
  logic        w_spc, r_spc;
  logic [31:0] w_spc_val, r_spc_val;

  // divider
  logic                w_div_start, w_div_done;
  logic [DIV_BITS-1:0] w_quo;

  // add/sub alignment
  logic        w_a_big;
  unp_t        w_big, w_sml;
  logic [7:0]  w_dexp;
  logic [4:0]  w_dcl;
  logic [26:0] w_big_x, w_sml_x, w_sml_al;
  logic        w_sticky;
  logic [27:0] w_sum;

  // EXEC result: value = r_mag / 2^46 * 2^(r_exp - bias)
  logic [47:0]        r_mag;
  logic signed [10:0] r_exp;
  logic               r_sgn;

  // NORM
  logic [47:0]        w_src;
  logic [5:0]         w_p;
  logic signed [10:0] w_nexp, r_nexp;
  logic [22:0]        r_nmant;
  logic               r_nsgn, r_nzero;

  logic [31:0] w_pack, r_out;

  assign fpuOut = r_out;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_UNPACK;
      ST_UNPACK: w_next = ST_EXEC;
      ST_EXEC:   if (r_op != OP_DIV || w_div_done) w_next = ST_NORM;
      ST_NORM:   w_next = ST_PACK;
      ST_PACK:   w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != ST_IDLE);
    done        = (r_state == ST_DONE);
    w_div_start = (r_state == ST_UNPACK);
  end

  // ---------------- operand capture ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_opa <= '0;
      r_opb <= '0;
      r_op  <= OP_ADD;
    end else if (r_state == ST_IDLE && start) begin
      r_opa <= opA;
      r_opb <= opB;
      r_op  <= op_t'(fpuOp);
    end
  end

  // ---------------- UNPACK ----------------
  always_comb begin
    w_fa     = fp32_t'(r_opa);
    w_fb     = fp32_t'(r_opb);
    w_a_zero = (w_fa.exp == 8'd0);
    w_a_inf  = (w_fa.exp == 8'hFF) && (w_fa.mant == '0);
    w_a_nan  = (w_fa.exp == 8'hFF) && (w_fa.mant != '0);
    w_b_zero = (w_fb.exp == 8'd0);
    w_b_inf  = (w_fb.exp == 8'hFF) && (w_fb.mant == '0);
    w_b_nan  = (w_fb.exp == 8'hFF) && (w_fb.mant != '0);

    // exp==0 is flushed to a signed zero, including denormals
    w_ua.sign = w_fa.sign;
    w_ua.exp  = w_a_zero ? 8'd0 : w_fa.exp;
    w_ua.mant = w_a_zero ? '0 : {1'b1, w_fa.mant};
    // SUB is ADD with B's sign flipped
    w_ub.sign = w_fb.sign ^ (r_op == OP_SUB);
    w_ub.exp  = w_b_zero ? 8'd0 : w_fb.exp;
    w_ub.mant = w_b_zero ? '0 : {1'b1, w_fb.mant};
    w_sx      = w_ua.sign ^ w_ub.sign;

    w_spc     = 1'b0;
    w_spc_val = '0;
    if (w_a_nan || w_b_nan) begin
      w_spc     = 1'b1;
      w_spc_val = QNAN;
    end else begin
      case (r_op)
        OP_ADD, OP_SUB: begin
          if (w_a_inf && w_b_inf) begin
            w_spc     = 1'b1;
            w_spc_val = (w_ua.sign != w_ub.sign) ? QNAN : f_inf(w_ua.sign);
          end else if (w_a_inf) begin
            w_spc     = 1'b1;
            w_spc_val = f_inf(w_ua.sign);
          end else if (w_b_inf) begin
            w_spc     = 1'b1;
            w_spc_val = f_inf(w_ub.sign);
          end
        end
        OP_MUL: begin
          if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
            w_spc     = 1'b1;
            w_spc_val = QNAN;
          end else if (w_a_inf || w_b_inf) begin
            w_spc     = 1'b1;
            w_spc_val = f_inf(w_sx);
          end
        end
        OP_DIV: begin
          if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spc     = 1'b1;
            w_spc_val = QNAN;
          end else if (w_a_inf) begin
            w_spc     = 1'b1;
            w_spc_val = f_inf(w_sx);
          end else if (w_b_inf) begin
            w_spc     = 1'b1;
            w_spc_val = f_zero(w_sx);
          end else if (w_b_zero) begin
            w_spc     = 1'b1;
            w_spc_val = f_inf(w_sx);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ua      <= '0;
      r_ub      <= '0;
      r_spc     <= 1'b0;
      r_spc_val <= '0;
    end else if (r_state == ST_UNPACK) begin
      r_ua      <= w_ua;
      r_ub      <= w_ub;
      r_spc     <= w_spc;
      r_spc_val <= w_spc_val;
    end
  end

  // Divider runs from the combinational unpack so EXEC starts iterating at once
  fpu_div_iter #(.DIV_BITS(DIV_BITS)) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (w_div_start),
    .dividend (w_ua.mant),
    .divisor  (w_ub.mant),
    .quotient (w_quo),
    .done     (w_div_done)
  );

  // ---------------- EXEC: add/sub alignment ----------------
  // Mantissas carry 3 extra low bits (guard/round/sticky) -> 26 fraction bits
  always_comb begin
    w_a_big  = ({r_ua.exp, r_ua.mant} >= {r_ub.exp, r_ub.mant});
    w_big    = w_a_big ? r_ua : r_ub;
    w_sml    = w_a_big ? r_ub : r_ua;
    w_dexp   = w_big.exp - w_sml.exp;
    w_dcl    = (w_dexp > 8'd26) ? 5'd26 : w_dexp[4:0];
    w_big_x  = {w_big.mant, 3'b000};
    w_sml_x  = {w_sml.mant, 3'b000};
    w_sticky = |(w_sml_x & ((27'd1 << w_dcl) - 27'd1));
    w_sml_al = (w_sml_x >> w_dcl) | {26'd0, w_sticky};
    if (w_big.sign ^ w_sml.sign) w_sum = {1'b0, w_big_x} - {1'b0, w_sml_al};
    else                         w_sum = {1'b0, w_big_x} + {1'b0, w_sml_al};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mag <= '0;
      r_exp <= '0;
      r_sgn <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      case (r_op)
        OP_ADD, OP_SUB: begin
          r_mag <= 48'(w_sum) << 20;
          r_exp <= $signed({3'b000, w_big.exp});
          // exact cancellation is +0 unless both effective signs are negative
          r_sgn <= (w_sum == 28'd0) ? (r_ua.sign & r_ub.sign) : w_big.sign;
        end
        OP_MUL: begin
          r_mag <= 48'(r_ua.mant) * 48'(r_ub.mant);
          r_exp <= $signed({3'b000, r_ua.exp}) + $signed({3'b000, r_ub.exp}) - L_BIAS;
          r_sgn <= r_ua.sign ^ r_ub.sign;
        end
        default: begin
          // quotient is taken directly from the divider in NORM
          r_mag <= '0;
          r_exp <= $signed({3'b000, r_ua.exp}) - $signed({3'b000, r_ub.exp}) + L_BIAS;
          r_sgn <= r_ua.sign ^ r_ub.sign;
        end
      endcase
    end
  end

  // ---------------- NORM ----------------
  // Quotient has DIV_BITS-1 fraction bits; align it to 46 like the others
  assign w_src  = (r_op == OP_DIV) ? (48'(w_quo) << (47 - DIV_BITS)) : r_mag;
  assign w_p    = lead_one(w_src);
  assign w_nexp = r_exp + $signed({5'b00000, w_p}) - 11'sd46;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_nexp  <= '0;
      r_nmant <= '0;
      r_nsgn  <= 1'b0;
      r_nzero <= 1'b0;
    end else if (r_state == ST_NORM) begin
      r_nexp  <= w_nexp;
      // leading one lands on bit 46; the 23 bits below it are the fraction
      r_nmant <= 23'(((w_p >= 6'd46) ? (w_src >> (w_p - 6'd46))
                                      : (w_src << (6'd46 - w_p))) >> 23);
      r_nsgn  <= r_sgn;
      r_nzero <= (w_src == 48'd0);
    end
  end

  // ---------------- PACK ----------------
  always_comb begin
    if (r_spc)                             w_pack = r_spc_val;
    else if (r_nzero || r_nexp <= 11'sd0)  w_pack = f_zero(r_nsgn);
    else if (r_nexp >= L_EXP_MAX)          w_pack = f_inf(r_nsgn);
    else                                   w_pack = {r_nsgn, r_nexp[7:0], r_nmant};
  end

  // Loaded on the PACK->DONE edge so the new value appears with done
  always_ff @(posedge clk) begin
    if (!reset_n)               r_out <= '0;
    else if (r_state == ST_PACK) r_out <= w_pack;
  end

endmodule

// File: tb/tb_fpu_seq.sv
module tb_fpu_seq;
  import fpu_pkg::*;

  localparam int DIV_BITS = 25;
  localparam int LAT_FAST = 5;
  localparam int LAT_DIV  = DIV_BITS + 4;

  logic        clk = 1'b0;
  logic        reset_n, start;
  logic [1:0]  fpuOp;
  logic [31:0] opA, opB;
  logic        busy, done;
  logic [31:0] fpuOut;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    string       nm;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  fpu_seq #(.DIV_BITS(DIV_BITS), .QNAN(QNAN_DEFAULT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .fpuOp   (fpuOp),
    .opA     (opA),
    .opB     (opB),
    .busy    (busy),
    .done    (done),
    .fpuOut  (fpuOut)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h, required %08h", nm, act, req);
    end
  endtask

  // Monitor: every done must match the oldest expected entry, value and cycle
  always @(negedge clk) begin
    if (done) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: done at cycle %0d fpuOut=%08h, required no done", cyc, fpuOut);
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.nm, " value"}, fpuOut, mon_e.val);
        chk({mon_e.nm, " done_cycle"}, 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Drive one request; on return we are at the negedge of cycle 1 (UNPACK)
  task automatic issue(input string nm, input op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res,
                       input bit expect_done, output int acc);
    @(negedge clk);
    fpuOp = op;
    opA   = a;
    opB   = b;
    start = 1'b1;
    acc   = cyc + 1;
    if (expect_done)
      sbq.push_back('{nm, res, acc + ((op == OP_DIV) ? LAT_DIV : LAT_FAST) - 1});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 80; i++) begin
      if (sbq.size() == 0 && !busy) break;
      @(negedge clk);
    end
    chk({nm, " drain"}, 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic run(input string nm, input op_t op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] res);
    int acc;
    issue(nm, op, a, b, res, 1'b1, acc);
    wait_idle(nm);
  endtask

  initial begin
    int acc;
    reset_n = 1'b0;
    start   = 1'b0;
    fpuOp   = 2'd0;
    opA     = '0;
    opB     = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset fpuOut", fpuOut, 32'h0);
    reset_n = 1'b1;

    // ADD with busy profile: high cycles 1-5, low in cycle 6
    issue("add_1_2", OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b1, acc);
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("add_1_2 busy c%0d", k), 32'(busy), 32'd1);
      @(negedge clk);
    end
    chk("add_1_2 busy c6", 32'(busy), 32'd0);
    wait_idle("add_1_2");

    run("sub_3_3",     OP_SUB, 32'h40400000, 32'h40400000, 32'h00000000);
    run("sub_n0_p0",   OP_SUB, 32'h80000000, 32'h00000000, 32'h80000000);
    run("add_n1_half", OP_ADD, 32'hBF800000, 32'h3F000000, 32'hBF000000);
    run("add_clamp",   OP_ADD, 32'h3F800000, 32'h30800000, 32'h3F800000);
    run("sub_clamp",   OP_SUB, 32'h3F800000, 32'h30800000, 32'h3F7FFFFF);
    run("mul_3_n2",    OP_MUL, 32'h40400000, 32'hC0000000, 32'hC0C00000);
    run("mul_ovf",     OP_MUL, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000);
    run("mul_15_15",   OP_MUL, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    run("mul_unf",     OP_MUL, 32'h00800000, 32'h00800000, 32'h00000000);

    // DIV 1/3 with an ignored start pulse in cycle 10
    issue("div_1_3", OP_DIV, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b1, acc);
    repeat (9) @(negedge clk);
    chk("div_1_3 busy c10", 32'(busy), 32'd1);
    fpuOp = OP_ADD;
    opA   = 32'h40000000;
    opB   = 32'h40000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("div_1_3");
    repeat (40) @(negedge clk);

    run("div_6_2",     OP_DIV, 32'h40C00000, 32'h40000000, 32'h40400000);
    run("inf_m_inf",   OP_ADD, 32'h7F800000, 32'hFF800000, 32'h7FC00000);
    run("div_1_0",     OP_DIV, 32'h3F800000, 32'h00000000, 32'h7F800000);
    run("mul_0_inf",   OP_MUL, 32'h00000000, 32'h7F800000, 32'h7FC00000);
    run("add_denorm",  OP_ADD, 32'h00000001, 32'h00000000, 32'h00000000);
    run("div_n1_inf",  OP_DIV, 32'hBF800000, 32'h7F800000, 32'h80000000);
    run("add_nan",     OP_ADD, 32'h7FC00001, 32'h3F800000, 32'h7FC00000);

    // Reset for one edge in cycle 10 of a DIV; that DIV must never complete
    issue("div_abort", OP_DIV, 32'h3F800000, 32'h40400000, 32'h0, 1'b0, acc);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort fpuOut", fpuOut, 32'h0);
    repeat (35) @(negedge clk);

    run("add_1_1",     OP_ADD, 32'h3F800000, 32'h3F800000, 32'h40000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
